// File: rtl/req_tag_issuer_pkg.sv
// Shared tag-pool sizing for the request tag issuer.
package req_tag_issuer_pkg;

    localparam int TAG_WIDTH_DEFAULT = 2;

    function automatic int ntags(input int tw);
        return 1 << tw;
    endfunction

endpackage

// File: rtl/req_tag_issuer_fifo.sv
// Issue-order tag queue: 2**B entries of W bits, modulo read/write pointers.
import req_tag_issuer_pkg::*;

module fifo #(
    parameter int B = TAG_WIDTH_DEFAULT,
    parameter int W = TAG_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_rd,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    output logic         o_empty,
    output logic         o_full,
    output logic [W-1:0] o_rdata
);

    logic [W-1:0] r_mem [ntags(B)];
    logic [B:0]   r_wptr;
    logic [B:0]   r_rptr;
    logic         w_push;
    logic         w_pop;

    assign w_push  = i_wr && !o_full;
    assign w_pop   = i_rd && !o_empty;
    assign o_empty = (r_wptr == r_rptr);
    // Extra pointer bit separates full from empty.
    assign o_full  = (r_wptr[B] != r_rptr[B]) &&
                     (r_wptr[B-1:0] == r_rptr[B-1:0]);
    assign o_rdata = r_mem[r_rptr[B-1:0]];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr[B-1:0]] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/req_tag_issuer.sv
// Stamps master requests with free tags, forwards them through a registered
// valid/ack stage and recycles tags in issue order on in-order responses.
import req_tag_issuer_pkg::*;

module req_tag_issuer #(
    parameter int TAG_WIDTH  = TAG_WIDTH_DEFAULT,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [DATA_WIDTH-1:0] reqdata_bi,
    output logic                  ack_o,
    output logic                  req_o,
    output logic [DATA_WIDTH-1:0] reqdata_bo,
    output logic [TAG_WIDTH-1:0]  reqtag_o,
    input  logic                  ack_i,
    input  logic                  tag_fifo_full_i,
    output logic                  tag_fifo_wrreq_o,
    output logic [TAG_WIDTH-1:0]  tag_fifo_wdata_o,
    input  logic                  resp_i,
    output logic [TAG_WIDTH:0]    outstanding_o,
    output logic                  err_o
);

    localparam int NTAGS = ntags(TAG_WIDTH);

    logic [NTAGS-1:0]     r_free;
    logic [TAG_WIDTH:0]   r_out;
    logic                 r_err;
    logic                 r_req;
    logic [DATA_WIDTH-1:0] r_data;
    logic [TAG_WIDTH-1:0] r_tag;

    logic [TAG_WIDTH-1:0] w_tag;
    logic                 w_any_free;
    logic                 w_accept;
    logic                 w_release;
    logic                 w_q_empty;
    logic                 w_q_full;
    logic [TAG_WIDTH-1:0] w_head;
    logic [NTAGS-1:0]     w_clr;
    logic [NTAGS-1:0]     w_set;

    // Lowest-index free tag from the registered bitmap only.
    always_comb begin
        w_tag = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (r_free[i])
                w_tag = TAG_WIDTH'(i);
        end
    end

    assign w_any_free = |r_free;
    assign ack_o      = w_any_free && !tag_fifo_full_i && (!r_req || ack_i);
    assign w_accept   = req_i && ack_o;
    assign w_release  = resp_i && !w_q_empty;

    assign w_clr = w_accept  ? (NTAGS'(1) << w_tag)  : '0;
    assign w_set = w_release ? (NTAGS'(1) << w_head) : '0;

    fifo #(
        .B (TAG_WIDTH),
        .W (TAG_WIDTH)
    ) u_order_q (
        .clk     (clk_i),
        .i_reset (rst_i),
        .i_rd    (w_release),
        .i_wr    (w_accept),
        .i_wdata (w_tag),
        .o_empty (w_q_empty),
        .o_full  (w_q_full),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_free <= '1;
            r_out  <= '0;
            r_err  <= 1'b0;
            r_req  <= 1'b0;
            r_data <= '0;
            r_tag  <= '0;
        end else begin
            r_free <= (r_free & ~w_clr) | w_set;
            case ({w_accept, w_release})
                2'b10:   r_out <= r_out + 1'b1;
                2'b01:   r_out <= r_out - 1'b1;
                default: r_out <= r_out;
            endcase
            if (resp_i && w_q_empty)
                r_err <= 1'b1;
            if (w_accept) begin
                r_req  <= 1'b1;
                r_data <= reqdata_bi;
                r_tag  <= w_tag;
            end else if (ack_i) begin
                r_req  <= 1'b0;
            end
        end
    end

    assign req_o            = r_req;
    assign reqdata_bo       = r_data;
    assign reqtag_o         = r_tag;
    assign tag_fifo_wrreq_o = w_accept;
    assign tag_fifo_wdata_o = w_tag;
    assign outstanding_o    = r_out;
    assign err_o            = r_err;

endmodule

// File: tb/tb_req_tag_issuer.sv
// Directed plus random bench for req_tag_issuer against a tag-pool model.
module tb_req_tag_issuer;

    localparam int TW = 2;
    localparam int DW = 32;
    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_i = 1'b0;
    logic [DW-1:0] reqdata_bi = '0;
    logic          ack_o;
    logic          req_o;
    logic [DW-1:0] reqdata_bo;
    logic [TW-1:0] reqtag_o;
    logic          ack_i = 1'b0;
    logic          tag_fifo_full_i = 1'b0;
    logic          tag_fifo_wrreq_o;
    logic [TW-1:0] tag_fifo_wdata_o;
    logic          resp_i = 1'b0;
    logic [TW:0]   outstanding_o;
    logic          err_o;

    int errors = 0;
    int checks = 0;

    // Model: free flags per tag, issue-order list of tags in use.
    bit        m_free [NT];
    int        m_q [$];
    bit        m_req;
    bit [31:0] m_data;
    int        m_tag;
    bit        m_err;
    bit        m_valid = 0;

    req_tag_issuer #(.TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .req_i            (req_i),
        .reqdata_bi       (reqdata_bi),
        .ack_o            (ack_o),
        .req_o            (req_o),
        .reqdata_bo       (reqdata_bo),
        .reqtag_o         (reqtag_o),
        .ack_i            (ack_i),
        .tag_fifo_full_i  (tag_fifo_full_i),
        .tag_fifo_wrreq_o (tag_fifo_wrreq_o),
        .tag_fifo_wdata_o (tag_fifo_wdata_o),
        .resp_i           (resp_i),
        .outstanding_o    (outstanding_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < NT; i++)
            if (m_free[i]) return i;
        return -1;
    endfunction

    // One clock: inputs applied after negedge, combinational outputs checked
    // before posedge, registered outputs checked at the following negedge.
    task automatic cyc(input bit rst, input bit req, input logic [31:0] d,
                       input bit acki, input bit full, input bit resp);
        int  lf;
        bit  ack_e;
        bit  acc;
        rst_i = rst; req_i = req; reqdata_bi = d;
        ack_i = acki; tag_fifo_full_i = full; resp_i = resp;
        #1;
        lf    = lowest_free();
        ack_e = (lf >= 0) && !full && (!m_req || acki);
        acc   = req && ack_e;
        if (m_valid) begin
            chk("ack_o", ack_o, ack_e);
            chk("wrreq", tag_fifo_wrreq_o, acc);
            if (acc) chk("wdata", tag_fifo_wdata_o, lf);
        end
        @(posedge clk);
        if (rst) begin
            foreach (m_free[i]) m_free[i] = 1;
            m_q.delete();
            m_req = 0; m_data = 0; m_tag = 0; m_err = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (resp) begin
                if (m_q.size() > 0) m_free[m_q.pop_front()] = 1;
                else m_err = 1;
            end
            if (acc) begin
                m_free[lf] = 0;
                m_q.push_back(lf);
                m_req = 1; m_data = d; m_tag = lf;
            end else if (acki) begin
                m_req = 0;
            end
        end
        @(negedge clk);
        if (m_valid) begin
            chk("req_o", req_o, m_req);
            chk("reqdata_bo", reqdata_bo, m_data);
            chk("reqtag_o", reqtag_o, m_tag);
            chk("outstanding", outstanding_o, m_q.size());
            chk("err_o", err_o, m_err);
        end
    endtask

    initial begin
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("reset_outstanding", outstanding_o, 0);
        chk("reset_req", req_o, 0);

        // Fill the pool: tags 0..3 in order.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 32'hA0 + i, 1, 0, 0);
            chk("tag_seq", reqtag_o, i);
        end
        chk("full_outstanding", outstanding_o, 4);
        cyc(0, 1, 32'hA4, 1, 0, 0);
        chk("full_stall_req", req_o, 0);

        // Free the oldest tag, then reuse it.
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 1, 32'hA4, 1, 0, 0);
        chk("reuse_tag0", reqtag_o, 0);
        chk("refill_outstanding", outstanding_o, 4);

        // Slave stall with free tags available.
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 32'hB0 + i, 0, 0, 0);
            chk("stall_data", reqdata_bo, 32'hA4);
        end
        cyc(0, 1, 32'hB8, 1, 0, 0);
        chk("stall_release_data", reqdata_bo, 32'hB8);

        // Reach two outstanding, then accept and release together.
        while (m_q.size() > 2) cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 1, 32'hC0, 1, 0, 1);
        chk("acc_rel_outstanding", outstanding_o, 2);

        // Sequencer FIFO full blocks accept.
        cyc(0, 1, 32'hD0, 1, 1, 0);
        chk("fifo_full_req", req_o, 0);

        // Spurious response at zero outstanding.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("err_set", err_o, 1);
        cyc(0, 1, 32'hE0, 1, 0, 0);
        cyc(0, 1, 32'hE1, 1, 0, 0);
        chk("err_sticky", err_o, 1);
        cyc(1, 1, 32'hE2, 1, 0, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_err", err_o, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                $urandom, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
